// File: rtl/i2s_pkg.sv
// Shared state type and cable pin maps for the user-port I2S receiver.
// usr_in bit order is {pin6, pin5, pin4, pin2}.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WAIT  = 2'd2
  } rx_state_t;

  localparam int PIN2 = 0;
  localparam int PIN4 = 1;
  localparam int PIN5 = 2;
  localparam int PIN6 = 3;

  localparam int STR_WS   = PIN5;
  localparam int STR_DATA = PIN2;
  localparam int STR_BCLK = PIN6;
  localparam int STR_MIDI = PIN4;

  localparam int CRS_WS   = PIN2;
  localparam int CRS_DATA = PIN5;
  localparam int CRS_BCLK = PIN4;
  localparam int CRS_MIDI = PIN6;

endpackage

// File: rtl/i2s_clk_meter.sv
// Pin synchroniser and glitch filter followed by a rising-edge detector and a
// saturating period counter (clk cycles between filtered rising edges).
module i2s_clk_meter #(
  parameter int DEB  = 2,
  parameter int CNTW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_pin,
  output logic            o_level,
  output logic            o_rise,
  output logic [CNTW-1:0] o_period
);

  localparam int DBW = (DEB > 1) ? $clog2(DEB) : 1;
  localparam logic [DBW-1:0]  DEB_LAST = DBW'(DEB - 1);
  localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};

  logic [1:0]      r_sync;
  logic [DBW-1:0]  r_deb;
  logic            r_level;
  logic            r_level_d;
  logic [CNTW-1:0] r_cnt;
  logic [CNTW-1:0] r_period;
  logic            w_rise;

  assign w_rise   = r_level & ~r_level_d;
  assign o_level  = r_level;
  assign o_rise   = w_rise;
  assign o_period = r_period;

  // Level only follows the synced pin after DEB consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync    <= 2'b00;
      r_deb     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_pin};
      r_level_d <= r_level;
      if (r_sync[1] == r_level) begin
        r_deb <= '0;
      end else if (r_deb == DEB_LAST) begin
        r_level <= r_sync[1];
        r_deb   <= '0;
      end else begin
        r_deb <= r_deb + 1'b1;
      end
    end
  end

  // A silent pin reads as a saturated (maximum) period.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_period <= '0;
    end else if (w_rise) begin
      r_period <= r_cnt;
      r_cnt    <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_period <= CNT_MAX;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_rx_auto.sv
// Auto-cabling I2S / left-justified stereo receiver: picks the bit clock by
// period, deserialises L/R words and presents them as one atomic pair.
module i2s_rx_auto
  import i2s_pkg::*;
#(
  parameter int DW      = 16,
  parameter int MAXBITS = 32,
  parameter int DEB     = 2,
  parameter int CNTW    = 5,
  parameter int HYST    = 8,
  parameter int TIMEOUT = 4096,
  parameter int LJ_MODE = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           usr_in,
  output logic                 midi_rx,
  output logic                 crossed,
  output logic                 locked,
  output logic signed [DW-1:0] sample_l,
  output logic signed [DW-1:0] sample_r,
  output logic                 sample_vld
);

  localparam int DBW = (DEB > 1) ? $clog2(DEB) : 1;
  localparam int LIM = (DW < MAXBITS) ? DW : MAXBITS;
  localparam int BCW = $clog2(LIM + 1);
  localparam int HCW = (HYST > 1) ? $clog2(HYST) : 1;
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [DBW-1:0] DEB_LAST  = DBW'(DEB - 1);
  localparam logic [BCW-1:0] BIT_LIM   = BCW'(LIM);
  localparam logic [HCW-1:0] HYST_LAST = HCW'(HYST - 1);
  localparam logic [WDW-1:0] WD_LAST   = WDW'(TIMEOUT - 1);
  localparam logic [WDW-1:0] WD_MAX    = WDW'(TIMEOUT);
  localparam logic [DW-1:0]  MSB_MASK  = {1'b1, {(DW-1){1'b0}}};

  logic            w_lvl4, w_rise4, w_lvl6, w_rise6;
  logic [CNTW-1:0] w_per4, w_per6;
  logic [1:0]      r_s1, r_s2, r_lvl25;
  logic [DBW-1:0]  r_deb25 [2];
  logic [3:0]      w_pins, w_rises;
  logic            w_ws, w_data, w_rise, w_tog, w_timeout, w_cable_chg, w_raw;
  logic            r_crossed, r_crossed_d, r_ws_prev, r_have_left, r_pair_go;
  logic [HCW-1:0]  r_hyst;
  logic [WDW-1:0]  r_wd;
  logic [BCW-1:0]  r_bitcnt;
  logic [DW-1:0]   r_buf, r_mask, r_hold_l, r_hold_r;
  rx_state_t       r_state;

  i2s_clk_meter #(.DEB(DEB), .CNTW(CNTW)) u_meter4 (
    .clk(clk), .reset(reset), .i_pin(usr_in[PIN4]),
    .o_level(w_lvl4), .o_rise(w_rise4), .o_period(w_per4)
  );

  i2s_clk_meter #(.DEB(DEB), .CNTW(CNTW)) u_meter6 (
    .clk(clk), .reset(reset), .i_pin(usr_in[PIN6]),
    .o_level(w_lvl6), .o_rise(w_rise6), .o_period(w_per6)
  );

  // Pins 2 and 5 share the meters' sync/filter timing so ws/data stay aligned to bclk.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1       <= 2'b00;
      r_s2       <= 2'b00;
      r_lvl25    <= 2'b00;
      r_deb25[0] <= '0;
      r_deb25[1] <= '0;
    end else begin
      r_s1 <= {usr_in[PIN5], usr_in[PIN2]};
      r_s2 <= r_s1;
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_lvl25[i]) begin
          r_deb25[i] <= '0;
        end else if (r_deb25[i] == DEB_LAST) begin
          r_lvl25[i] <= r_s2[i];
          r_deb25[i] <= '0;
        end else begin
          r_deb25[i] <= r_deb25[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_pins        = 4'b0000;
    w_pins[PIN2]  = r_lvl25[0];
    w_pins[PIN4]  = w_lvl4;
    w_pins[PIN5]  = r_lvl25[1];
    w_pins[PIN6]  = w_lvl6;
    w_rises       = 4'b0000;
    w_rises[PIN4] = w_rise4;
    w_rises[PIN6] = w_rise6;
  end

  assign w_ws        = r_crossed ? w_pins[CRS_WS]    : w_pins[STR_WS];
  assign w_data      = r_crossed ? w_pins[CRS_DATA]  : w_pins[STR_DATA];
  assign w_rise      = r_crossed ? w_rises[CRS_BCLK] : w_rises[STR_BCLK];
  assign midi_rx     = r_crossed ? w_pins[CRS_MIDI]  : w_pins[STR_MIDI];
  assign w_tog       = w_rise & (w_ws != r_ws_prev);
  assign w_timeout   = ~w_rise & (r_wd == WD_LAST);
  assign w_cable_chg = r_crossed ^ r_crossed_d;
  assign w_raw       = (w_per4 <= w_per6);
  assign crossed     = r_crossed;

  // The faster of pin4/pin6 is the bit clock; HYST agreeing votes needed to switch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_crossed   <= 1'b0;
      r_crossed_d <= 1'b0;
      r_hyst      <= '0;
    end else begin
      r_crossed_d <= r_crossed;
      if (w_rise4) begin
        if (w_raw == r_crossed) begin
          r_hyst <= '0;
        end else if (r_hyst == HYST_LAST) begin
          r_crossed <= w_raw;
          r_hyst    <= '0;
        end else begin
          r_hyst <= r_hyst + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd <= '0;
    end else if (w_rise) begin
      r_wd <= '0;
    end else if (r_wd != WD_MAX) begin
      r_wd <= r_wd + 1'b1;
    end
  end

  // A ws toggle commits the finished word before the same rise's bit is considered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ws_prev   <= 1'b0;
      r_have_left <= 1'b0;
      r_pair_go   <= 1'b0;
      r_bitcnt    <= '0;
      r_buf       <= '0;
      r_mask      <= '0;
      r_hold_l    <= '0;
      r_hold_r    <= '0;
    end else begin
      r_pair_go <= 1'b0;
      if (w_rise) r_ws_prev <= w_ws;
      if (w_timeout || w_cable_chg) begin
        r_state     <= IDLE;
        r_have_left <= 1'b0;
      end else if (w_tog) begin
        if (r_state != IDLE) begin
          if (!r_ws_prev) begin
            r_hold_l    <= r_buf;
            r_have_left <= 1'b1;
          end else begin
            r_hold_r    <= r_buf;
            r_pair_go   <= r_have_left;
            r_have_left <= 1'b0;
          end
        end
        r_state <= SHIFT;
        if (LJ_MODE != 0) begin
          r_buf    <= {w_data, {(DW-1){1'b0}}};
          r_mask   <= MSB_MASK >> 1;
          r_bitcnt <= BCW'(1);
        end else begin
          r_buf    <= '0;
          r_mask   <= MSB_MASK;
          r_bitcnt <= '0;
        end
      end else if (w_rise && r_state == SHIFT) begin
        if (r_bitcnt < BIT_LIM) begin
          r_buf    <= r_buf | (r_mask & {DW{w_data}});
          r_mask   <= r_mask >> 1;
          r_bitcnt <= r_bitcnt + 1'b1;
        end else begin
          r_state <= WAIT;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_l   <= '0;
      sample_r   <= '0;
      sample_vld <= 1'b0;
      locked     <= 1'b0;
    end else begin
      sample_vld <= 1'b0;
      if (w_timeout) begin
        sample_l <= '0;
        sample_r <= '0;
        locked   <= 1'b0;
      end else if (r_pair_go) begin
        sample_l   <= r_hold_l;
        sample_r   <= r_hold_r;
        sample_vld <= 1'b1;
        locked     <= 1'b1;
      end
    end
  end

endmodule
